// File: rtl/demux2x32_buf_if.sv
// Bundle of the result-input and two write-back output channels of demux2x32_buf.
// The master side drives results in and consumes both ports; the slave side is the distributor.
interface demux2x32_buf_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [4:0]       in_rd;
    logic [WIDTH-1:0] in_data;

    logic             out0_valid;
    logic             out0_ready;
    logic [4:0]       out0_rd;
    logic [WIDTH-1:0] out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [4:0]       out1_rd;
    logic [WIDTH-1:0] out1_data;

    logic [CW-1:0]    cnt0;
    logic [CW-1:0]    cnt1;

    modport master (
        output in_valid, in_sel, in_rd, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_rd, out0_data,
               out1_valid, out1_rd, out1_data, cnt0, cnt1
    );

    modport slave (
        input  in_valid, in_sel, in_rd, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_rd, out0_data,
               out1_valid, out1_rd, out1_data, cnt0, cnt1
    );
endinterface

// File: rtl/demux2x32_buf.sv
// Buffered 1-to-2 result distributor: one tagged result stream steered into two
// independent FIFOs (port 0 integer write-back, port 1 FP write-back).
module demux2x32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          clrn,
    demux2x32_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 5 + WIDTH;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Per-port state, index 0 = integer port, index 1 = FP port.
    logic [EW-1:0] mem_q  [2][DEPTH];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic [EW-1:0] head_s [2];

    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic [1:0] ready_s;
    logic       in_ready_s;

    assign ready_s = {bus.out1_ready, bus.out0_ready};

    // Acceptance depends only on the selected port's registered occupancy.
    always_comb begin
        in_ready_s = 1'b1;
        if (bus.in_sel) begin
            in_ready_s = (cnt_q[1] != CNT_FULL);
        end else begin
            in_ready_s = (cnt_q[0] != CNT_FULL);
        end
    end

    // Push/pop decode and next-state for pointers and occupancy of both ports.
    always_comb begin
        push_s = 2'b00;
        pop_s  = 2'b00;
        for (int p = 0; p < 2; p++) begin
            wptr_d[p] = wptr_q[p];
            rptr_d[p] = rptr_q[p];
            cnt_d[p]  = cnt_q[p];

            push_s[p] = bus.in_valid && in_ready_s && (bus.in_sel == 1'(p));
            pop_s[p]  = (cnt_q[p] != CNT_ZERO) && ready_s[p];

            if (push_s[p]) begin
                wptr_d[p] = wptr_q[p] + PW'(1);
            end else begin
                wptr_d[p] = wptr_q[p];
            end

            if (pop_s[p]) begin
                rptr_d[p] = rptr_q[p] + PW'(1);
            end else begin
                rptr_d[p] = rptr_q[p];
            end

            case ({push_s[p], pop_s[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CW'(1);
                2'b01:   cnt_d[p] = cnt_q[p] - CW'(1);
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    // Pointer and occupancy registers; clear discards any buffered entries.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= {PW{1'b0}};
                rptr_q[p] <= {PW{1'b0}};
                cnt_q[p]  <= CNT_ZERO;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= wptr_d[p];
                rptr_q[p] <= rptr_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
        end
    end

    // Entry storage; contents are don't-care while a slot is unoccupied, so no reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
                mem_q[p][wptr_q[p]] <= {bus.in_rd, bus.in_data};
            end
        end
    end

    // Head entry of each port, forced to zero while the port is empty.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (cnt_q[p] != CNT_ZERO) begin
                head_s[p] = mem_q[p][rptr_q[p]];
            end else begin
                head_s[p] = {EW{1'b0}};
            end
        end
    end

    assign bus.in_ready   = in_ready_s;

    assign bus.out0_valid = (cnt_q[0] != CNT_ZERO);
    assign bus.out0_rd    = head_s[0][EW-1 -: 5];
    assign bus.out0_data  = head_s[0][WIDTH-1:0];

    assign bus.out1_valid = (cnt_q[1] != CNT_ZERO);
    assign bus.out1_rd    = head_s[1][EW-1 -: 5];
    assign bus.out1_data  = head_s[1][WIDTH-1:0];

    assign bus.cnt0       = cnt_q[0];
    assign bus.cnt1       = cnt_q[1];
endmodule
